// File: rtl/uart_rx_frame_ctrl.sv
// Frame-level receive controller: turns the UART byte stream into frames.
// A frame is HEADER, LEN, LEN payload bytes and a checksum (LEN + payload, mod 256).
// Payload bytes are streamed to an external buffer. Each frame ends with one
// FRAME_VALID or FRAME_ERR pulse.
module uart_rx_frame_ctrl #(
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter int unsigned MAX_LEN     = 32,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned TIMEOUT_CYC = 4000
) (
    input  logic              SYS_CLK,
    input  logic              RST_N,
    input  logic [7:0]        RX_D,
    input  logic              RX_DONE,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [7:0]        WR_DATA,
    output logic              FRAME_VALID,
    output logic [7:0]        FRAME_LEN,
    output logic              FRAME_ERR,
    output logic [1:0]        ERR_CODE,
    output logic              BUSY
);

    localparam logic [7:0]  MaxLen      = 8'(MAX_LEN);
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StHunt, StLen, StPayload, StCheck} state_e;

    state_e            state_q, state_d;
    logic [2:0]        sync_q;
    logic [15:0]       idle_q, idle_d;
    logic [7:0]        len_q, len_d, csum_q, csum_d, cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              fv_q, fv_d, fe_q, fe_d;
    logic [7:0]        fl_q, fl_d;
    logic [1:0]        ec_q, ec_d;
    logic              byte_stb, timeout, len_bad;

    // sync_q[1] is the synchronized level, sync_q[2] its delayed copy for edge detection.
    assign byte_stb = sync_q[1] & ~sync_q[2];
    // The counter value TimeoutLast means this edge is the TIMEOUT_CYC-th idle cycle.
    assign timeout  = (state_q != StHunt) && (idle_q == TimeoutLast);
    assign len_bad  = (RX_D == 8'd0) || (RX_D > MaxLen);

    // RX_DONE synchronizer and edge-detect delay line
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) sync_q <= '0;
        else        sync_q <= {sync_q[1:0], RX_DONE};
    end

    // State register plus all datapath and output registers
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StHunt;
            idle_q    <= '0;
            len_q     <= '0;
            csum_q    <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            fv_q      <= 1'b0;
            fl_q      <= '0;
            fe_q      <= 1'b0;
            ec_q      <= '0;
        end else begin
            state_q   <= state_d;
            idle_q    <= idle_d;
            len_q     <= len_d;
            csum_q    <= csum_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            fv_q      <= fv_d;
            fl_q      <= fl_d;
            fe_q      <= fe_d;
            ec_q      <= ec_d;
        end
    end

    // Next-state logic; timeout wins over a coincident strobe
    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = StHunt;
        end else if (byte_stb) begin
            case (state_q)
                StHunt:    if (RX_D == HEADER) state_d = StLen;
                StLen:     state_d = len_bad ? StHunt : StPayload;
                StPayload: if (cnt_q == len_q - 8'd1) state_d = StCheck;
                StCheck:   state_d = StHunt;
                default:   state_d = StHunt;
            endcase
        end
    end

    // Datapath and registered-output next values
    always_comb begin
        idle_d    = (state_q == StHunt || byte_stb || timeout) ? 16'd0 : idle_q + 16'd1;
        len_d     = len_q;
        csum_d    = csum_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        fv_d      = 1'b0;
        fl_d      = fl_q;
        fe_d      = 1'b0;
        ec_d      = ec_q;
        if (timeout) begin
            fe_d = 1'b1;
            ec_d = 2'd3;
        end else if (byte_stb) begin
            case (state_q)
                StLen: begin
                    if (len_bad) begin
                        fe_d = 1'b1;
                        ec_d = 2'd1;
                    end else begin
                        len_d  = RX_D;
                        csum_d = RX_D;
                        cnt_d  = 8'd0;
                    end
                end
                StPayload: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[ADDR_W-1:0];
                    wr_data_d = RX_D;
                    csum_d    = csum_q + RX_D;
                    cnt_d     = cnt_q + 8'd1;
                end
                StCheck: begin
                    if (RX_D == csum_q) begin
                        fv_d = 1'b1;
                        fl_d = len_q;
                    end else begin
                        fe_d = 1'b1;
                        ec_d = 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    assign WR_EN       = wr_en_q;
    assign WR_ADDR     = wr_addr_q;
    assign WR_DATA     = wr_data_q;
    assign FRAME_VALID = fv_q;
    assign FRAME_LEN   = fl_q;
    assign FRAME_ERR   = fe_q;
    assign ERR_CODE    = ec_q;
    assign BUSY        = (state_q != StHunt);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed and random byte streams checked against
// a frame-parsing reference model operating on whole byte queues.
module tb_uart_rx_frame_ctrl;

    localparam logic [7:0]  HEADER      = 8'hA5;
    localparam int unsigned MAX_LEN     = 32;
    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned TIMEOUT_CYC = 4000;

    logic              SYS_CLK = 1'b0;
    logic              RST_N;
    logic [7:0]        RX_D;
    logic              RX_DONE;
    logic              WR_EN;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [7:0]        WR_DATA;
    logic              FRAME_VALID;
    logic [7:0]        FRAME_LEN;
    logic              FRAME_ERR;
    logic [1:0]        ERR_CODE;
    logic              BUSY;

    uart_rx_frame_ctrl #(
        .HEADER      (HEADER),
        .MAX_LEN     (MAX_LEN),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .SYS_CLK     (SYS_CLK),
        .RST_N       (RST_N),
        .RX_D        (RX_D),
        .RX_DONE     (RX_DONE),
        .WR_EN       (WR_EN),
        .WR_ADDR     (WR_ADDR),
        .WR_DATA     (WR_DATA),
        .FRAME_VALID (FRAME_VALID),
        .FRAME_LEN   (FRAME_LEN),
        .FRAME_ERR   (FRAME_ERR),
        .ERR_CODE    (ERR_CODE),
        .BUSY        (BUSY)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    int checks = 0;
    int errors = 0;

    // Observed events; writes are {addr, data}, results are {kind, value}
    // with kind 1 = valid (value = len) and kind 2 = error (value = code).
    logic [15:0] wr_q[$];
    logic [15:0] res_q[$];
    logic [15:0] exp_wr[$];
    logic [15:0] exp_res[$];
    logic [7:0]  stim_q[$];
    logic [7:0]  exp_last_len  = 8'd0;
    logic [1:0]  exp_last_code = 2'd0;

    int   cyc = 0;
    int   last_wr_cyc = 0;
    int   err_cyc = 0;
    logic busy_prev = 1'b0;
    logic busy_before_err = 1'b0;
    int   overlap = 0;
    int   busy_bad = 0;

    always @(posedge SYS_CLK) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle
    always @(negedge SYS_CLK) begin
        if (WR_EN) begin
            wr_q.push_back({8'(WR_ADDR), WR_DATA});
            last_wr_cyc <= cyc;
        end
        if (FRAME_VALID) res_q.push_back({8'h01, FRAME_LEN});
        if (FRAME_ERR) begin
            res_q.push_back({8'h02, 6'd0, ERR_CODE});
            err_cyc         <= cyc;
            busy_before_err <= busy_prev;
        end
        if ((FRAME_VALID || FRAME_ERR) && BUSY) busy_bad <= busy_bad + 1;
        if ((FRAME_VALID && FRAME_ERR) || (WR_EN && (FRAME_VALID || FRAME_ERR)))
            overlap <= overlap + 1;
        busy_prev <= BUSY;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: parse the whole byte queue into expected writes and results.
    task automatic model_stream();
        int i;
        int n;
        int len;
        int sum;
        i = 0;
        n = stim_q.size();
        while (i < n) begin
            if (stim_q[i] != HEADER) begin
                i++;
                continue;
            end
            i++;
            if (i >= n) break;
            len = int'(stim_q[i]);
            i++;
            if (len == 0 || len > int'(MAX_LEN)) begin
                exp_res.push_back(16'h0201);
                exp_last_code = 2'd1;
                continue;
            end
            sum = len;
            for (int k = 0; k < len && i < n; k++) begin
                exp_wr.push_back({8'(k), stim_q[i]});
                sum = (sum + int'(stim_q[i])) % 256;
                i++;
            end
            if (i >= n) break;
            if (stim_q[i] == 8'(sum)) begin
                exp_res.push_back({8'h01, 8'(len)});
                exp_last_len = 8'(len);
            end else begin
                exp_res.push_back(16'h0202);
                exp_last_code = 2'd2;
            end
            i++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge SYS_CLK);
        RX_D    = b;
        RX_DONE = 1'b1;
        repeat (hold) @(negedge SYS_CLK);
        RX_DONE = 1'b0;
        repeat (4) @(negedge SYS_CLK);
    endtask

    task automatic compare_queues(input string tag);
        int nw;
        int nr;
        chk({tag, " wr_count"}, 32'(wr_q.size()), 32'(exp_wr.size()));
        chk({tag, " res_count"}, 32'(res_q.size()), 32'(exp_res.size()));
        nw = (wr_q.size() < exp_wr.size()) ? wr_q.size() : exp_wr.size();
        nr = (res_q.size() < exp_res.size()) ? res_q.size() : exp_res.size();
        for (int i = 0; i < nw; i++) chk({tag, " write"}, 32'(wr_q[i]), 32'(exp_wr[i]));
        for (int i = 0; i < nr; i++) chk({tag, " result"}, 32'(res_q[i]), 32'(exp_res[i]));
        chk({tag, " FRAME_LEN held"}, 32'(FRAME_LEN), 32'(exp_last_len));
        chk({tag, " ERR_CODE held"}, 32'(ERR_CODE), 32'(exp_last_code));
        chk({tag, " BUSY idle"}, 32'(BUSY), 32'd0);
        wr_q.delete();
        res_q.delete();
        exp_wr.delete();
        exp_res.delete();
    endtask

    // hold == 0 picks a random RX_DONE high time per byte
    task automatic run_stream(input string tag, input int hold);
        model_stream();
        foreach (stim_q[j]) send_byte(stim_q[j], (hold == 0) ? int'($urandom_range(4, 12)) : hold);
        stim_q.delete();
        repeat (20) @(negedge SYS_CLK);
        compare_queues(tag);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, " WR_EN"}, 32'(WR_EN), 32'd0);
        chk({tag, " WR_ADDR"}, 32'(WR_ADDR), 32'd0);
        chk({tag, " WR_DATA"}, 32'(WR_DATA), 32'd0);
        chk({tag, " FRAME_VALID"}, 32'(FRAME_VALID), 32'd0);
        chk({tag, " FRAME_LEN"}, 32'(FRAME_LEN), 32'd0);
        chk({tag, " FRAME_ERR"}, 32'(FRAME_ERR), 32'd0);
        chk({tag, " ERR_CODE"}, 32'(ERR_CODE), 32'd0);
        chk({tag, " BUSY"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        #(2_000_000 * 10);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int         len;
        int         sum;
        int         nj;

        RST_N   = 1'b0;
        RX_DONE = 1'b0;
        RX_D    = 8'h00;
        repeat (5) @(negedge SYS_CLK);
        check_outputs_zero("reset");
        RST_N = 1'b1;
        repeat (3) @(negedge SYS_CLK);

        // Good 3-byte frame
        stim_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        run_stream("good3", 0);

        // Leading junk then checksum mismatch
        stim_q = '{8'h00, 8'h7F, 8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
        run_stream("badsum", 0);

        // Bad lengths, then a maximum-length frame
        stim_q = '{8'hA5, 8'h00, 8'hA5, 8'h21, 8'hA5, 8'h20};
        repeat (32) stim_q.push_back(8'h01);
        stim_q.push_back(8'h40);
        run_stream("lenbounds", 0);

        // Inter-byte timeout
        send_byte(8'hA5, 6);
        send_byte(8'h04, 6);
        send_byte(8'h01, 6);
        send_byte(8'h02, 6);
        repeat (TIMEOUT_CYC + 50) @(negedge SYS_CLK);
        chk("timeout res_count", 32'(res_q.size()), 32'd1);
        chk("timeout result", 32'((res_q.size() > 0) ? res_q[0] : 16'hFFFF), 32'h0203);
        chk("timeout wr_count", 32'(wr_q.size()), 32'd2);
        chk("timeout latency", 32'(err_cyc - last_wr_cyc), 32'(TIMEOUT_CYC));
        chk("timeout busy before", 32'(busy_before_err), 32'd1);
        chk("timeout BUSY after", 32'(BUSY), 32'd0);
        wr_q.delete();
        res_q.delete();
        exp_last_code = 2'd3;
        stim_q = '{8'hA5, 8'h01, 8'h05, 8'h06};
        run_stream("after_timeout", 0);

        // Long RX_DONE level, back-to-back frames, header byte as payload
        stim_q = '{8'hA5, 8'h01, 8'hA5, 8'hA6, 8'hA5, 8'h01, 8'h00, 8'h01};
        run_stream("longhold", 500);

        // Random frames
        for (int f = 0; f < 14; f++) begin
            nj = int'($urandom_range(0, 3));
            for (int j = 0; j < nj; j++) begin
                b = 8'($urandom);
                if (b == HEADER) b = 8'h00;
                stim_q.push_back(b);
            end
            stim_q.push_back(HEADER);
            len = int'($urandom_range(0, MAX_LEN + 4));
            stim_q.push_back(8'(len));
            if (len != 0 && len <= int'(MAX_LEN)) begin
                sum = len;
                for (int j = 0; j < len; j++) begin
                    b = 8'($urandom);
                    stim_q.push_back(b);
                    sum = (sum + int'(b)) % 256;
                end
                if ($urandom_range(0, 3) == 0) stim_q.push_back(8'(sum) ^ 8'($urandom_range(1, 255)));
                else                           stim_q.push_back(8'(sum));
            end
            run_stream("random", 0);
        end

        // Reset in the middle of a payload
        send_byte(8'hA5, 5);
        send_byte(8'h05, 5);
        send_byte(8'h01, 5);
        send_byte(8'h02, 5);
        @(negedge SYS_CLK);
        RST_N = 1'b0;
        #1;
        check_outputs_zero("midreset");
        repeat (4) @(negedge SYS_CLK);
        chk("midreset no pulses", 32'(res_q.size()), 32'd0);
        wr_q.delete();
        res_q.delete();
        exp_last_len  = 8'd0;
        exp_last_code = 2'd0;
        RST_N = 1'b1;
        repeat (3) @(negedge SYS_CLK);
        stim_q = '{8'hA5, 8'h01, 8'h07, 8'h08};
        run_stream("after_reset", 0);

        chk("valid/err/wr overlap", 32'(overlap), 32'd0);
        chk("BUSY during pulse", 32'(busy_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Frame-level receive controller behind the byte-level UART receiver.
- Consumes received bytes (data + done flag), hunts for a header, and parses length, payload and checksum.
- Writes the payload into an external buffer and reports each frame as good or errored.
- Sits between the UART receive block and the command/register logic on SYS_CLK.

Parameters:
HEADER, 8'hA5, frame start byte
MAX_LEN, 32, largest legal payload length in bytes (1..255)
ADDR_W, 5, payload buffer address width; must satisfy 2**ADDR_W >= MAX_LEN
TIMEOUT_CYC, 4000, max SYS_CLK cycles allowed between consecutive bytes inside a frame

Ports:
SYS_CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
RX_D  in  8  received byte from UART receiver; stable while RX_DONE high
RX_DONE  in  1  UART byte-done flag; level, high for many cycles, not SYS_CLK-aligned
WR_EN  out  1  payload buffer write strobe, one cycle per payload byte
WR_ADDR  out  ADDR_W  payload byte index 0..LEN-1
WR_DATA  out  8  payload byte
FRAME_VALID  out  1  one-cycle pulse: frame accepted, checksum good
FRAME_LEN  out  8  length of last accepted frame; held until next accept
FRAME_ERR  out  1  one-cycle pulse: frame aborted
ERR_CODE  out  2  1=bad length, 2=checksum mismatch, 3=inter-byte timeout; held until next error
BUSY  out  1  high in any state other than HUNT

Behaviour:
- Reset (async, RST_N low): state HUNT.
  - All outputs 0. Counters, checksum accumulator and sync flops cleared.
- Byte strobe:
  - RX_DONE passes through a 2-flop synchronizer, then a rising-edge detector.
  - byte_stb is a one-cycle pulse 3 SYS_CLK cycles after RX_DONE rises.
  - RX_D is sampled on byte_stb.
  - A level held high produces exactly one strobe.
- States:
  - HUNT:
    - On byte_stb with RX_D==HEADER -> LEN.
    - Any other byte is ignored, and no error is raised.
  - LEN:
    - On byte_stb with RX_D==0 or RX_D>MAX_LEN -> FRAME_ERR, code 1, -> HUNT.
    - Otherwise latch len = RX_D, set csum = RX_D, cnt = 0 -> PAYLOAD.
  - PAYLOAD, on each byte_stb:
    - WR_EN=1, WR_ADDR=cnt[ADDR_W-1:0], WR_DATA=RX_D, asserted the cycle after byte_stb.
    - csum = csum + RX_D (mod 256); cnt = cnt + 1.
    - After the byte with cnt==len-1 -> CHECK.
  - CHECK, on byte_stb:
    - If RX_D == csum: FRAME_VALID=1, FRAME_LEN=len.
    - Else: FRAME_ERR=1, ERR_CODE=2.
    - Either way -> HUNT.
    - Pulses appear the cycle after byte_stb.
- Timeout:
  - A 16-bit idle counter clears on every byte_stb and increments each cycle while state != HUNT.
  - On reaching TIMEOUT_CYC: FRAME_ERR=1, ERR_CODE=3, -> HUNT, counter cleared.
  - A byte_stb arriving in the same cycle as the timeout is discarded.
- Bytes in HUNT never time out.
- Payload written before an abort stays in the buffer. Consumers must use FRAME_VALID/FRAME_LEN only.
- A header byte inside LEN/PAYLOAD/CHECK is treated as data; there is no resync mid-frame.
- Back-to-back frames:
  - HUNT is entered on the cycle of the result pulse, so a header byte on the very next strobe is accepted.
  - Minimum strobe spacing is 4 cycles, guaranteed by the RX_DONE high time.
- FRAME_VALID and FRAME_ERR are never high together. WR_EN never coincides with either.
- Mid-frame reset: immediate return to HUNT with no pulses; partial data is discarded.

Test Plan:
1. Bytes A5,03,11,22,33,69 (csum = 03+11+22+33 = 69) -> WR_EN x3 at addr 0,1,2 with data 11,22,33; one FRAME_VALID; FRAME_LEN=3; no FRAME_ERR.
2. Bytes 00,7F,A5,02,10,20,31 -> leading junk ignored; writes 10,20; csum 32 != 31 -> FRAME_ERR with ERR_CODE=2; FRAME_VALID never high.
3. A5,00 then A5,21 (MAX_LEN=32) -> two FRAME_ERR pulses, ERR_CODE=1, zero WR_EN; then A5,20 plus 32 bytes of 01 plus checksum 40 -> FRAME_VALID, FRAME_LEN=32, last WR_ADDR=31.
4. A5,04,01,02 then silence -> FRAME_ERR with ERR_CODE=3 exactly TIMEOUT_CYC cycles after the last strobe; BUSY falls the same cycle; next A5,01,05,06 -> FRAME_VALID.
5. RX_DONE held high 500 cycles per byte, two back-to-back frames A5,01,A5,A6 and A5,01,00,01 -> one strobe per byte; payload A5 written at addr 0; two FRAME_VALID pulses.
6. RST_N pulsed low mid-PAYLOAD -> all outputs 0 and BUSY=0 immediately; no pulses; following frame A5,01,07,08 -> FRAME_VALID, FRAME_LEN=1.
